pspin_ctrl_regfile: RTL
=======================

# pspin_ctrl_regfile

Parametrised AXI-Lite control/status register file for the PsPIN accelerator, sitting between the host AXI-Lite interconnect and the cluster, MPQ, stdout and matching-engine logic. Successor to the single-channel control block. Adds a native AXI-Lite slave with SLVERR reporting, per-cluster stdout FIFO channels, sticky end-of-computation (EOC) status with a level interrupt, and shadowed matching-engine rules committed atomically.

## Interface
- ADDR_WIDTH, 16, AXI-Lite address width
- DATA_WIDTH, 32, data width (fixed 32)
- NUM_CLUSTERS, 2, clusters; also the number of stdout channels (1..32)
- NUM_MPQ, 256, MPQ full bits; MPQ_WORDS = ceil(NUM_MPQ/32)
- UMATCH_WIDTH, 32, match rule word width
- UMATCH_ENTRIES, 16, match rules (≤64)
- UMATCH_MODES, 2, match modes
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axil_aw*/w*/b*/ar*/r*  standard AXI-Lite slave, ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH=4
- cl_fetch_en_o  out  NUM_CLUSTERS  cluster fetch enable
- aux_rst_o  out  1  cluster reset, high
- cl_eoc_i, cl_busy_i  in  NUM_CLUSTERS  cluster status
- mpq_full_i  in  NUM_MPQ  MPQ full flags
- irq_o  out  1  |(eoc_sticky & irq_en)
- stdout_rd_en  out  NUM_CLUSTERS  one-cycle pop per channel
- stdout_dout  in  32*NUM_CLUSTERS  channel c at [32c+:32]
- stdout_data_valid  in  NUM_CLUSTERS  channel head valid
- match_mode_o  out  $clog2(UMATCH_MODES)
- match_valid_o  out  1
- match_idx_o, match_mask_o, match_start_o, match_end_o  out  UMATCH_WIDTH*UMATCH_ENTRIES  active (committed) rules

## Operation
- Map (byte addresses):
  - 0x0000 fetch_en RW; 0x0004 aux_rst RW (bit0)
  - 0x0100 eoc RO; 0x0104 busy RO; 0x0108 eoc_sticky W1C; 0x010C irq_en RW
  - 0x0200+4k MPQ word k RO, k<MPQ_WORDS; bits ≥NUM_MPQ read 0
  - 0x1000+4c stdout pop channel c RO; 0x1100 stdout_data_valid RO
  - 0x2000 mode RW; 0x2004 valid RW (bit0); 0x2008 commit WO (bit0=1 commits, reads 0)
  - 0x2100/0x2200/0x2300/0x2400 + 4e: shadow idx/mask/start/end[e] RW
- RW fields honour wstrb per byte; unimplemented bits read 0.
- Unmapped address, or write to RO: SLVERR (2'b10), no state change; unmapped read returns 0xFFFFFFFF. Otherwise OKAY.
- Sticky: eoc_sticky[c] set every cycle cl_eoc_i[c]=1; W1C clears; set wins on same-cycle clear.
- Stdout pop: read of channel c with stdout_data_valid[c]=1 returns stdout_dout[c], pulses stdout_rd_en[c] exactly one cycle. With valid=0 returns 0xFFFFFFFF, OKAY, no pop.
- Commit: a write with bit0=1 copies all shadow rules to match_*_o in one edge. Shadow writes never affect outputs until commit.
- Reset values: fetch_en 0, aux_rst_o 1, irq_en 0, sticky 0, mode/valid 0, shadow and active rules 0, stdout_rd_en 0, bvalid/rvalid 0, irq_o 0.

## Timing
- Write: awready=wready=awvalid&wvalid&!bvalid&!rst (same cycle both). Register/outputs update at the acceptance edge T; bvalid from T+1, held until bready.
- Read: arready=!rvalid&!rst. Accept at T; rdata/rresp/rvalid from T+1, held until rready. stdout_rd_en pulses in cycle T+1 only.
- Read and write accepted in same cycle are independent; a read of a register written in the same cycle returns the old value.
- Status inputs sampled one cycle (eoc/busy/MPQ reads reflect inputs at T-1 edge). irq_o registered, lags sticky by 0 cycles (combinational from registers).
- rst mid-transaction drops bvalid/rvalid; no pop pulse is emitted.

## Test plan
- After reset: read 0x0004 -> 0x00000001, aux_rst_o=1; write 0x0 to 0x0004 -> aux_rst_o=0 at next cycle, bresp OKAY.
- Write 0xDEADBEEF to 0x2100, read back 0xDEADBEEF, match_idx_o[31:0]=0; write 0x1 to 0x2008 -> match_idx_o[31:0]=0xDEADBEEF, 0x2008 reads 0.
- cl_eoc_i=2'b10 one cycle, irq_en=0x2 -> 0x0108 reads 0x2, irq_o=1; W1C 0x2 while eoc held -> stays 0x2; release then W1C -> 0, irq_o=0.
- Channel 1 valid with dout 0x41: read 0x1004 -> 0x41, stdout_rd_en=2'b10 one cycle; valid=0 read -> 0xFFFFFFFF, no pulse.
- Write to 0x0100 and read 0x3000 -> SLVERR both, read data 0xFFFFFFFF, eoc unchanged; bready held low 5 cycles -> bvalid held, no new write accepted.

Source files
------------

// File: rtl/pspin_ctrl_regfile.sv
// pspin_ctrl_regfile: AXI-Lite control/status register file for PsPIN.
// Cluster control, sticky EOC + IRQ, MPQ status, stdout pop, match rules.
module pspin_ctrl_regfile #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CLUSTERS   = 2,
    parameter int NUM_MPQ        = 256,
    parameter int UMATCH_WIDTH   = 32,
    parameter int UMATCH_ENTRIES = 16,
    parameter int UMATCH_MODES   = 2,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8,
    localparam int MODE_W        = (UMATCH_MODES > 1) ? $clog2(UMATCH_MODES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_WIDTH-1:0]                  s_axil_awaddr,
    input  logic                                   s_axil_awvalid,
    output logic                                   s_axil_awready,
    input  logic [DATA_WIDTH-1:0]                  s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]                  s_axil_wstrb,
    input  logic                                   s_axil_wvalid,
    output logic                                   s_axil_wready,
    output logic [1:0]                             s_axil_bresp,
    output logic                                   s_axil_bvalid,
    input  logic                                   s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]                  s_axil_araddr,
    input  logic                                   s_axil_arvalid,
    output logic                                   s_axil_arready,
    output logic [DATA_WIDTH-1:0]                  s_axil_rdata,
    output logic [1:0]                             s_axil_rresp,
    output logic                                   s_axil_rvalid,
    input  logic                                   s_axil_rready,
    output logic [NUM_CLUSTERS-1:0]                cl_fetch_en_o,
    output logic                                   aux_rst_o,
    input  logic [NUM_CLUSTERS-1:0]                cl_eoc_i,
    input  logic [NUM_CLUSTERS-1:0]                cl_busy_i,
    input  logic [NUM_MPQ-1:0]                     mpq_full_i,
    output logic                                   irq_o,
    output logic [NUM_CLUSTERS-1:0]                stdout_rd_en,
    input  logic [32*NUM_CLUSTERS-1:0]             stdout_dout,
    input  logic [NUM_CLUSTERS-1:0]                stdout_data_valid,
    output logic [MODE_W-1:0]                      match_mode_o,
    output logic                                   match_valid_o,
    output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_idx_o,
    output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_mask_o,
    output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_start_o,
    output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_end_o
);
    localparam int AW        = ADDR_WIDTH;
    localparam int UW        = UMATCH_WIDTH;
    localparam int MPQ_WORDS = (NUM_MPQ + 31) / 32;
    localparam int EW        = (UMATCH_ENTRIES > 1) ? $clog2(UMATCH_ENTRIES) : 1;

    typedef enum logic [3:0] {
        W_NONE, W_FETCH, W_AUX, W_CLR, W_IRQ,
        W_MODE, W_VALID, W_COMMIT, W_TAB
    } wsel_t;

    logic [NUM_CLUSTERS-1:0]  fetch_en_q, irq_en_q, sticky_q;
    logic [NUM_CLUSTERS-1:0]  eoc_q, busy_q, rd_en_q, clr, rpop;
    logic                     aux_rst_q, valid_q;
    logic [MODE_W-1:0]        mode_q;
    logic [MPQ_WORDS*32-1:0]  mpq_q, mpq_pad;
    logic [UW-1:0]            sh_q  [4][UMATCH_ENTRIES];
    logic [UW-1:0]            act_q [4][UMATCH_ENTRIES];
    logic                     bvalid_q, rvalid_q;
    logic [1:0]               bresp_q, rresp_q;
    logic [31:0]              rdata_q;
    logic                     aw_hs, ar_hs, rerr;
    logic [AW-1:0]            wa, ra;
    wsel_t                    wsel;
    logic [1:0]               wtab;
    logic [EW-1:0]            went;
    logic [31:0]              wold, wnew, rd;

    assign s_axil_awready = s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~rst;
    assign s_axil_wready  = s_axil_awready;
    assign aw_hs          = s_axil_awready;
    assign s_axil_arready = ~rvalid_q & ~rst;
    assign ar_hs          = s_axil_arvalid & s_axil_arready;

    assign wa      = s_axil_awaddr & ~AW'(3);
    assign ra      = s_axil_araddr & ~AW'(3);
    assign mpq_pad = (MPQ_WORDS*32)'(mpq_full_i);
    assign clr     = (aw_hs && wsel == W_CLR) ? wnew[NUM_CLUSTERS-1:0] : '0;

    // Write decode: select target, fetch its old value, merge byte strobes.
    always_comb begin
        wsel = W_NONE;
        wtab = '0;
        went = '0;
        wold = '0;
        if (wa == AW'(16'h0000)) begin
            wsel = W_FETCH;
            wold = 32'(fetch_en_q);
        end else if (wa == AW'(16'h0004)) begin
            wsel = W_AUX;
            wold = 32'(aux_rst_q);
        end else if (wa == AW'(16'h0108)) begin
            wsel = W_CLR;
        end else if (wa == AW'(16'h010C)) begin
            wsel = W_IRQ;
            wold = 32'(irq_en_q);
        end else if (wa == AW'(16'h2000)) begin
            wsel = W_MODE;
            wold = 32'(mode_q);
        end else if (wa == AW'(16'h2004)) begin
            wsel = W_VALID;
            wold = 32'(valid_q);
        end else if (wa == AW'(16'h2008)) begin
            wsel = W_COMMIT;
        end else if (wa[AW-1:8] >= (AW-8)'(8'h21) &&
                     wa[AW-1:8] <= (AW-8)'(8'h24) &&
                     int'(wa[7:2]) < UMATCH_ENTRIES) begin
            wsel = W_TAB;
            wtab = 2'(wa[AW-1:8] - (AW-8)'(8'h21));
            went = wa[EW+1:2];
            wold = 32'(sh_q[wtab][went]);
        end
        wnew = wold;
        for (int i = 0; i < 4; i++) begin
            if (s_axil_wstrb[i]) wnew[8*i+:8] = s_axil_wdata[8*i+:8];
        end
    end

    // Read decode: data, error flag and stdout pop vector for the address.
    always_comb begin
        rd   = '1;
        rerr = 1'b1;
        rpop = '0;
        if (ra == AW'(16'h0000)) begin
            rd = 32'(fetch_en_q); rerr = 1'b0;
        end else if (ra == AW'(16'h0004)) begin
            rd = 32'(aux_rst_q); rerr = 1'b0;
        end else if (ra == AW'(16'h0100)) begin
            rd = 32'(eoc_q); rerr = 1'b0;
        end else if (ra == AW'(16'h0104)) begin
            rd = 32'(busy_q); rerr = 1'b0;
        end else if (ra == AW'(16'h0108)) begin
            rd = 32'(sticky_q); rerr = 1'b0;
        end else if (ra == AW'(16'h010C)) begin
            rd = 32'(irq_en_q); rerr = 1'b0;
        end else if (ra == AW'(16'h1100)) begin
            rd = 32'(stdout_data_valid); rerr = 1'b0;
        end else if (ra == AW'(16'h2000)) begin
            rd = 32'(mode_q); rerr = 1'b0;
        end else if (ra == AW'(16'h2004)) begin
            rd = 32'(valid_q); rerr = 1'b0;
        end else if (ra == AW'(16'h2008)) begin
            rd = '0; rerr = 1'b0;
        end
        for (int k = 0; k < MPQ_WORDS; k++) begin
            if (ra == AW'(32'h200 + 4*k)) begin
                rd = mpq_q[32*k+:32]; rerr = 1'b0;
            end
        end
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            if (ra == AW'(32'h1000 + 4*c)) begin
                rerr = 1'b0;
                if (stdout_data_valid[c]) begin
                    rd      = stdout_dout[32*c+:32];
                    rpop[c] = 1'b1;
                end
            end
        end
        for (int t = 0; t < 4; t++) begin
            for (int e = 0; e < UMATCH_ENTRIES; e++) begin
                if (ra == AW'(32'h2100 + 32'h100*t + 4*e)) begin
                    rd = 32'(sh_q[t][e]); rerr = 1'b0;
                end
            end
        end
    end

    // Status sampling and sticky EOC; a set in the same cycle beats W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            eoc_q    <= '0;
            busy_q   <= '0;
            mpq_q    <= '0;
            sticky_q <= '0;
        end else begin
            eoc_q    <= cl_eoc_i;
            busy_q   <= cl_busy_i;
            mpq_q    <= mpq_pad;
            sticky_q <= (sticky_q & ~clr) | cl_eoc_i;
        end
    end

    // Control registers written through the AXI-Lite write channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_en_q <= '0;
            aux_rst_q  <= 1'b1;
            irq_en_q   <= '0;
            mode_q     <= '0;
            valid_q    <= 1'b0;
        end else if (aw_hs) begin
            case (wsel)
                W_FETCH: fetch_en_q <= wnew[NUM_CLUSTERS-1:0];
                W_AUX:   aux_rst_q  <= wnew[0];
                W_IRQ:   irq_en_q   <= wnew[NUM_CLUSTERS-1:0];
                W_MODE:  mode_q     <= wnew[MODE_W-1:0];
                W_VALID: valid_q    <= wnew[0];
                default: ;
            endcase
        end
    end

    // Shadow match rules; commit copies every shadow rule in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '{default: '{default: '0}};
            act_q <= '{default: '{default: '0}};
        end else if (aw_hs) begin
            if (wsel == W_TAB) sh_q[wtab][went] <= wnew[UW-1:0];
            if (wsel == W_COMMIT && wnew[0]) act_q <= sh_q;
        end
    end

    // Response channels and the one-cycle stdout pop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
            rd_en_q  <= '0;
        end else begin
            rd_en_q <= '0;
            if (aw_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (wsel == W_NONE) ? 2'b10 : 2'b00;
            end else if (s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd;
                rresp_q  <= rerr ? 2'b10 : 2'b00;
                rd_en_q  <= rpop;
            end else if (s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;
    assign cl_fetch_en_o = fetch_en_q;
    assign aux_rst_o     = aux_rst_q;
    assign irq_o         = |(sticky_q & irq_en_q);
    assign stdout_rd_en  = rd_en_q;
    assign match_mode_o  = mode_q;
    assign match_valid_o = valid_q;

    for (genvar e = 0; e < UMATCH_ENTRIES; e++) begin : g_act
        assign match_idx_o[UW*e+:UW]   = act_q[0][e];
        assign match_mask_o[UW*e+:UW]  = act_q[1][e];
        assign match_start_o[UW*e+:UW] = act_q[2][e];
        assign match_end_o[UW*e+:UW]   = act_q[3][e];
    end
endmodule
